// File: rtl/zoom_out_ctrl.sv
// Frame sequencer for the nearest-neighbour zoom-out datapath: per output row it
// streams one source row into the line buffer, then writes the decimated row out.
module zoom_out_ctrl #(
  parameter int largura = 320,
  parameter int altura  = 240,
  parameter int fator   = 2,
  parameter int ADDR_W  = 17,
  localparam int OW  = largura / fator,
  localparam int OH  = altura / fator,
  localparam int CW  = (largura > 1) ? $clog2(largura) : 1,
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1,
  localparam int RW  = (OH > 1) ? $clog2(OH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              lb_wr_en,
  output logic [CW-1:0]     lb_wr_idx,
  output logic [7:0]        lb_wr_data,
  output logic [OCW-1:0]    pix_sel_idx,
  input  logic [7:0]        pix_sel_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data,
  input  logic              dst_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CW-1:0]     COL_LAST  = CW'(largura - 1);
  localparam logic [OCW-1:0]    OCOL_LAST = OCW'(OW - 1);
  localparam logic [RW-1:0]     OROW_LAST = RW'(OH - 1);
  localparam logic [ADDR_W-1:0] SROW_STEP = ADDR_W'(fator * largura);
  localparam logic [ADDR_W-1:0] DROW_STEP = ADDR_W'(OW);

  state_t state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [OCW-1:0]    ocol_q, ocol_d;
  logic [RW-1:0]     orow_q, orow_d;
  // Row base addresses are accumulated so no multiplier is needed.
  logic [ADDR_W-1:0] sbase_q, sbase_d;
  logic [ADDR_W-1:0] dbase_q, dbase_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              src_rd_en_q, src_rd_en_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              lb_wr_en_q, lb_wr_en_d;
  logic [CW-1:0]     lb_wr_idx_q, lb_wr_idx_d;
  logic [7:0]        lb_wr_data_q, lb_wr_data_d;
  logic [OCW-1:0]    pix_sel_idx_q, pix_sel_idx_d;
  logic              dst_wr_en_q, dst_wr_en_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    sbase_d = sbase_q;
    dbase_d = dbase_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          col_d   = '0;
          orow_d  = '0;
          sbase_d = '0;
          dbase_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (col_q == COL_LAST) begin
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
        ocol_d  = '0;
      end
      S_WRITE: begin
        if (dst_wr_en_q && dst_ready) begin
          if (ocol_q == OCOL_LAST) begin
            state_d = S_NEXT;
          end else begin
            ocol_d = ocol_q + OCW'(1);
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_NEXT: begin
        if (orow_q == OROW_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          orow_d  = orow_q + RW'(1);
          col_d   = '0;
          sbase_d = sbase_q + SROW_STEP;
          dbase_d = dbase_q + DROW_STEP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    src_rd_en_d = (state_d == S_READ);
    dst_wr_en_d = (state_d == S_WRITE);
    if (src_rd_en_d) begin
      src_addr_d = sbase_d + ADDR_W'(col_d);
    end else begin
      src_addr_d = '0;
    end
    if (dst_wr_en_d) begin
      dst_addr_d    = dbase_d + ADDR_W'(ocol_d);
      pix_sel_idx_d = ocol_d;
    end else begin
      dst_addr_d    = '0;
      pix_sel_idx_d = '0;
    end
    // The pixel read this cycle lands in the line buffer next cycle.
    lb_wr_en_d = src_rd_en_q;
    if (src_rd_en_q) begin
      lb_wr_idx_d  = col_q;
      lb_wr_data_d = src_data;
    end else begin
      lb_wr_idx_d  = '0;
      lb_wr_data_d = 8'h00;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      ocol_q        <= '0;
      orow_q        <= '0;
      sbase_q       <= '0;
      dbase_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      src_rd_en_q   <= 1'b0;
      src_addr_q    <= '0;
      lb_wr_en_q    <= 1'b0;
      lb_wr_idx_q   <= '0;
      lb_wr_data_q  <= 8'h00;
      pix_sel_idx_q <= '0;
      dst_wr_en_q   <= 1'b0;
      dst_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      ocol_q        <= ocol_d;
      orow_q        <= orow_d;
      sbase_q       <= sbase_d;
      dbase_q       <= dbase_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      src_rd_en_q   <= src_rd_en_d;
      src_addr_q    <= src_addr_d;
      lb_wr_en_q    <= lb_wr_en_d;
      lb_wr_idx_q   <= lb_wr_idx_d;
      lb_wr_data_q  <= lb_wr_data_d;
      pix_sel_idx_q <= pix_sel_idx_d;
      dst_wr_en_q   <= dst_wr_en_d;
      dst_addr_q    <= dst_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign src_rd_en   = src_rd_en_q;
  assign src_addr    = src_addr_q;
  assign lb_wr_en    = lb_wr_en_q;
  assign lb_wr_idx   = lb_wr_idx_q;
  assign lb_wr_data  = lb_wr_data_q;
  assign pix_sel_idx = pix_sel_idx_q;
  assign dst_wr_en   = dst_wr_en_q;
  assign dst_addr    = dst_addr_q;
  // Decimated pixel comes back combinationally for the held pix_sel_idx.
  assign dst_data    = dst_wr_en_q ? pix_sel_data : 8'h00;

endmodule

// File: tb/tb_zoom_out_ctrl.sv
// Bench for zoom_out_ctrl: a small 8x4 instance with RAM / line-buffer / decimator
// models and a default-size 320x240 instance for a full-frame run.
module tb_zoom_out_ctrl;
  localparam int L = 8, H = 4, F = 2, AW = 17;
  localparam int OW = L / F, OH = H / F;
  localparam int FRAME_CYC = 1 + OH * (L + OW + 2);
  localparam int BL = 320, BH = 240, BOW = 160, BOH = 120;
  localparam int BIG_CYC = 1 + BOH * (BL + BOW + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, dst_ready;
  logic busy, done, src_rd_en, lb_wr_en, dst_wr_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0] src_data, lb_wr_data, pix_sel_data, dst_data;
  logic [2:0] lb_wr_idx;
  logic [1:0] pix_sel_idx;

  int vectors = 0, miscompares = 0;

  logic [7:0] smem [0:31];
  logic [7:0] lb   [0:L-1];
  logic [7:0] dmem [0:OW*OH-1];
  logic [7:0] expv [0:OW*OH-1];
  int wr_cnt = 0, done_cnt = 0, overlap_cnt = 0, stab_cnt = 0, lbchk_cnt = 0;

  assign src_data     = src_rd_en ? smem[src_addr[4:0]] : 8'h00;
  assign pix_sel_data = lb[int'(pix_sel_idx) * F];

  zoom_out_ctrl #(.largura(L), .altura(H), .fator(F), .ADDR_W(AW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
    .lb_wr_en(lb_wr_en), .lb_wr_idx(lb_wr_idx), .lb_wr_data(lb_wr_data),
    .pix_sel_idx(pix_sel_idx), .pix_sel_data(pix_sel_data),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data), .dst_ready(dst_ready));

  // Memory models plus cycle-level protocol observers for the small instance
  logic prev_stall = 1'b0, prev_rd = 1'b0;
  logic [AW-1:0] prev_daddr, prev_saddr;
  logic [7:0] prev_ddata, prev_sdata;
  logic [1:0] prev_pidx;
  always @(posedge clk) begin
    if (lb_wr_en) lb[lb_wr_idx] <= lb_wr_data;
    if (dst_wr_en && dst_ready) begin
      dmem[dst_addr[2:0]] <= dst_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (src_rd_en && dst_wr_en) overlap_cnt <= overlap_cnt + 1;
    if (rst_n && prev_stall && (!dst_wr_en || dst_addr !== prev_daddr ||
        dst_data !== prev_ddata || pix_sel_idx !== prev_pidx))
      stab_cnt <= stab_cnt + 1;
    if (rst_n && prev_rd && (!lb_wr_en || int'(lb_wr_idx) != int'(prev_saddr) % L ||
        lb_wr_data !== prev_sdata))
      lbchk_cnt <= lbchk_cnt + 1;
    prev_stall <= dst_wr_en && !dst_ready;
    prev_daddr <= dst_addr;
    prev_ddata <= dst_data;
    prev_pidx  <= pix_sel_idx;
    prev_rd    <= src_rd_en;
    prev_saddr <= src_addr;
    prev_sdata <= src_data;
  end

  // Default-size instance: source pixel value is the low address byte
  logic b_start, b_busy, b_done, b_src_rd_en, b_lb_wr_en, b_dst_wr_en;
  logic b_dst_ready;
  logic [AW-1:0] b_src_addr, b_dst_addr;
  logic [7:0] b_src_data, b_lb_wr_data, b_pix_data, b_dst_data, b_dst160;
  logic [8:0] b_lb_wr_idx;
  logic [7:0] b_pix_idx;
  logic [7:0] blb [0:BL-1];
  int b_wr_cnt = 0, b_err = 0;

  assign b_dst_ready = 1'b1;
  assign b_src_data  = b_src_rd_en ? b_src_addr[7:0] : 8'h00;
  assign b_pix_data  = blb[int'(b_pix_idx) * 2];

  zoom_out_ctrl big (
    .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .src_rd_en(b_src_rd_en), .src_addr(b_src_addr), .src_data(b_src_data),
    .lb_wr_en(b_lb_wr_en), .lb_wr_idx(b_lb_wr_idx), .lb_wr_data(b_lb_wr_data),
    .pix_sel_idx(b_pix_idx), .pix_sel_data(b_pix_data),
    .dst_wr_en(b_dst_wr_en), .dst_addr(b_dst_addr), .dst_data(b_dst_data),
    .dst_ready(b_dst_ready));

  // Scoreboard for the default-size frame: dst[r*OW+c] must be src[(r*fator)*largura + c*fator]
  always @(posedge clk) begin
    if (b_lb_wr_en) blb[b_lb_wr_idx] <= b_lb_wr_data;
    if (b_dst_wr_en && b_dst_ready) begin
      b_wr_cnt <= b_wr_cnt + 1;
      if (b_dst_data !== 8'(((int'(b_dst_addr) / BOW) * 2) * BL + (int'(b_dst_addr) % BOW) * 2))
        b_err <= b_err + 1;
      if (int'(b_dst_addr) == 160) b_dst160 <= b_dst_data;
    end
  end

  task automatic fill_src(input bit ramp);
    for (int a = 0; a < 32; a++) smem[a] = ramp ? 8'(a) : 8'($urandom_range(0, 255));
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        expv[r*OW + c] = smem[(r*F)*L + c*F];
  endtask

  task automatic run_frame(input int mode, input bit hold, output int ncyc,
                           output int nstall, output bit to);
    ncyc = 0; nstall = 0; to = 1'b0;
    @(negedge clk); start = 1'b1; dst_ready = 1'b1;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      ncyc++;
      case (mode)
        0:       dst_ready = 1'b1;
        1:       dst_ready = ~dst_ready;
        default: dst_ready = 1'($urandom_range(0, 1));
      endcase
      if (dst_wr_en && !dst_ready) nstall++;
      if (done) begin start = 1'b0; break; end
      if (ncyc > 2000) begin to = 1'b1; break; end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int ncyc, input int nstall,
                             input bit to, input int wr0, input int dn0, input int ov0);
    vectors++;
    if (to) begin miscompares++; $display("FAIL %s_timeout: done never seen", name); end
    vectors++;
    if (ncyc !== FRAME_CYC + nstall) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d expected %0d", name, ncyc, FRAME_CYC + nstall);
    end
    vectors++;
    if (wr_cnt - wr0 !== OW*OH) begin
      miscompares++;
      $display("FAIL %s_writes: got %0d expected %0d", name, wr_cnt - wr0, OW*OH);
    end
    vectors++;
    if (done_cnt - dn0 !== 1) begin
      miscompares++;
      $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt - dn0);
    end
    vectors++;
    if (overlap_cnt != ov0) begin
      miscompares++;
      $display("FAIL %s_rd_wr_overlap: got %0d expected 0", name, overlap_cnt - ov0);
    end
    for (int i = 0; i < OW*OH; i++) begin
      vectors++;
      if (dmem[i] !== expv[i]) begin
        miscompares++;
        $display("FAIL %s_dst[%0d]: got %0d expected %0d", name, i, dmem[i], expv[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dst_ready = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, src_rd_en, src_addr, lb_wr_en, lb_wr_idx, lb_wr_data, pix_sel_idx,
         dst_wr_en, dst_addr, dst_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero expected all 0");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || src_rd_en !== 1'b0 || dst_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%0b rd=%0b wr=%0b expected 0", busy, src_rd_en, dst_wr_en);
    end
  endtask

  task automatic test_basic;
    int n, s, w0, d0, o0; bit to;
    logic [7:0] ref_t1 [0:7];
    ref_t1 = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd16, 8'd18, 8'd20, 8'd22};
    fill_src(1'b1);
    for (int i = 0; i < 8; i++) expv[i] = ref_t1[i];
    w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt;
    run_frame(0, 1'b0, n, s, to);
    vectors++;
    if (n !== 29) begin miscompares++; $display("FAIL t1_done_cycle: got %0d expected 29", n); end
    check_frame("t1", n, s, to, w0, d0, o0);
  endtask

  task automatic test_stall;
    int n, s, w0, d0, o0, st0; bit to;
    fill_src(1'b1);
    w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt; st0 = stab_cnt;
    run_frame(1, 1'b0, n, s, to);
    check_frame("t2_toggle", n, s, to, w0, d0, o0);
    vectors++;
    if (s == 0) begin miscompares++; $display("FAIL t2_stalls: got 0 expected >0"); end
    for (int k = 0; k < 4; k++) begin
      fill_src(1'b0);
      w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt;
      run_frame(2, 1'b0, n, s, to);
      check_frame("rand", n, s, to, w0, d0, o0);
    end
    vectors++;
    if (stab_cnt != st0) begin
      miscompares++;
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", stab_cnt - st0);
    end
  endtask

  task automatic test_back_to_back;
    int n, s, w0, d0, o0; bit to;
    fill_src(1'b0);
    w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt;
    run_frame(0, 1'b1, n, s, to);
    check_frame("t3_held", n, s, to, w0, d0, o0);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL t3_single_run: busy=%0b extra_done=%0d expected 0/0", busy, done_cnt - d0);
    end
    w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt;
    run_frame(0, 1'b0, n, s, to);
    check_frame("t3_second", n, s, to, w0, d0, o0);
  endtask

  task automatic test_reset_abort;
    int n, s, w0, d0, o0, k; bit to;
    fill_src(1'b0);
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; dst_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(dst_wr_en && int'(dst_addr) >= OW) && k < 200) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 200) begin miscompares++; $display("FAIL t4_reach_row1: got timeout expected row1 write"); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, src_rd_en, src_addr, lb_wr_en, lb_wr_idx, lb_wr_data, pix_sel_idx,
         dst_wr_en, dst_addr, dst_data} !== '0) begin
      miscompares++;
      $display("FAIL t4_abort_outputs: got nonzero expected all 0");
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_no_done: got done=%0d busy=%0b expected 0/0", done_cnt - d0, busy);
    end
    fill_src(1'b0);
    w0 = wr_cnt; d0 = done_cnt; o0 = overlap_cnt;
    run_frame(2, 1'b0, n, s, to);
    check_frame("t4_after", n, s, to, w0, d0, o0);
  endtask

  task automatic test_lb_pipeline;
    int qa[$], qi[$], qd[$]; int n, c0;
    fill_src(1'b1);
    c0 = lbchk_cnt; n = 0;
    @(negedge clk); start = 1'b1; dst_ready = 1'b1;
    @(posedge clk);
    while (n < 500) begin
      @(negedge clk); start = 1'b0; n++;
      if (src_rd_en) qa.push_back(int'(src_addr));
      if (lb_wr_en) begin qi.push_back(int'(lb_wr_idx)); qd.push_back(int'(lb_wr_data)); end
      if (done) break;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (qa.size() != 2*L || qi.size() != 2*L) begin
      miscompares++;
      $display("FAIL t5_counts: got rd=%0d wr=%0d expected %0d", qa.size(), qi.size(), 2*L);
    end else begin
      for (int k = 0; k < L; k++) begin
        vectors++;
        if (qa[L+k] != 2*L + k || qi[L+k] != k || qd[L+k] != 2*L + k) begin
          miscompares++;
          $display("FAIL t5_row1[%0d]: got addr=%0d idx=%0d data=%0d expected %0d/%0d/%0d",
                   k, qa[L+k], qi[L+k], qd[L+k], 2*L + k, k, 2*L + k);
        end
      end
    end
    vectors++;
    if (lbchk_cnt != c0) begin
      miscompares++;
      $display("FAIL t5_lb_delay: got %0d bad cycles expected 0", lbchk_cnt - c0);
    end
  endtask

  task automatic test_default_frame;
    int n;
    n = 0;
    @(negedge clk); b_start = 1'b1;
    @(posedge clk);
    @(negedge clk); b_start = 1'b0; n = 1;
    while (!b_done && n < BIG_CYC + 1000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    vectors++;
    if (n !== BIG_CYC) begin miscompares++; $display("FAIL t6_latency: got %0d expected %0d", n, BIG_CYC); end
    vectors++;
    if (b_wr_cnt !== BOW*BOH) begin miscompares++; $display("FAIL t6_writes: got %0d expected %0d", b_wr_cnt, BOW*BOH); end
    vectors++;
    if (b_err !== 0) begin miscompares++; $display("FAIL t6_data: got %0d bad pixels expected 0", b_err); end
    vectors++;
    if (b_dst160 !== 8'h80) begin miscompares++; $display("FAIL t6_dst160: got %0h expected 80", b_dst160); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_lb_pipeline();
    test_default_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
